// File: rtl/tv_checker.sv
// Test-vector sequencer/checker: replays {valid, stim, exp, mask} words from an
// internal RAM into a DUT, samples its response after SETTLE cycles and tallies masked mismatches.
module tv_checker #(
    parameter int IN_W   = 12,
    parameter int OUT_W  = 15,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH),
    parameter int SETTLE = 1,
    parameter int ERR_W  = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      vec_we_i,
    input  logic [AW-1:0]             vec_waddr_i,
    input  logic [IN_W+2*OUT_W:0]     vec_wdata_i,
    output logic [IN_W-1:0]           dut_in_o,
    input  logic [OUT_W-1:0]          dut_out_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic [AW:0]               vec_count_o,
    output logic [ERR_W-1:0]          errors_o,
    output logic [AW-1:0]             first_err_idx_o,
    output logic [OUT_W-1:0]          first_err_got_o
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // FETCH | idx presented to the vector RAM
    // APPLY | RAM word latched; terminator ends the run, else stimulus driven
    // WAIT  | settle countdown, dut_in held stable
    // CHECK | dut_out compared under mask, counters updated
    // DONE  | results held until the next start
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_APPLY = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int VW = 1 + IN_W + 2 * OUT_W;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [VW-1:0]    mem_q [DEPTH];
    logic [VW-1:0]    rdata_q;

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [IN_W-1:0]  din_q, din_d;
    logic [OUT_W-1:0] exp_q, exp_d;
    logic [OUT_W-1:0] mask_q, mask_d;
    logic [SW-1:0]    wcnt_q, wcnt_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [AW-1:0]    fidx_q, fidx_d;
    logic [OUT_W-1:0] fgot_q, fgot_d;

    logic             busy;
    logic             rd_valid;
    logic [IN_W-1:0]  rd_stim;
    logic [OUT_W-1:0] rd_exp;
    logic [OUT_W-1:0] rd_mask;
    logic             mism;

    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign rd_valid = rdata_q[VW-1];
    assign rd_stim  = rdata_q[2*OUT_W +: IN_W];
    assign rd_exp   = rdata_q[OUT_W +: OUT_W];
    assign rd_mask  = rdata_q[0 +: OUT_W];
    assign mism     = |((dut_out_i ^ exp_q) & mask_q);

    // Vector RAM has no reset so it maps onto block RAM; writes are locked out during a run.
    always_ff @(posedge clk_i) begin
        if (vec_we_i && !busy) begin
            mem_q[vec_waddr_i] <= vec_wdata_i;
        end
        rdata_q <= mem_q[idx_q];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        din_d   = din_q;
        exp_d   = exp_q;
        mask_d  = mask_q;
        wcnt_d  = wcnt_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fgot_d  = fgot_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fgot_d  = '0;
                end
            end
            S_FETCH: begin
                state_d = S_APPLY;
            end
            S_APPLY: begin
                exp_d  = rd_exp;
                mask_d = rd_mask;
                if (!rd_valid) begin
                    state_d = S_DONE;
                end else begin
                    din_d   = rd_stim;
                    wcnt_d  = SW'(SETTLE - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            S_CHECK: begin
                if (mism) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (err_q == '0) begin
                        fidx_d = idx_q;
                        fgot_d = dut_out_i;
                    end
                end
                cnt_d = cnt_q + 1'b1;
                // The last RAM entry ends the run; the index never wraps to 0.
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            din_q   <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fgot_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fgot_q  <= fgot_d;
        end
    end

    assign dut_in_o        = din_q;
    assign busy_o          = busy;
    assign done_o          = (state_q == S_DONE);
    assign pass_o          = (state_q == S_DONE) && (err_q == '0);
    assign vec_count_o     = cnt_q;
    assign errors_o        = err_q;
    assign first_err_idx_o = fidx_q;
    assign first_err_got_o = fgot_q;

endmodule

// File: doc/tv_checker.md
Name: tv_checker

Overview:
- Synthesizable, parametrised test-vector sequencer and checker for combinational or short-latency blocks, for example the ARM decoder, ALU and condition logic.
- Stores stimulus/expected/mask vectors in an internal RAM and drives the DUT inputs one vector at a time.
- Samples DUT outputs after a configurable settle time and compares them under a per-vector mask.
- Counts errors and records the first failure, so decoder and datapath checks can run on FPGA as well as in simulation.

Parameters:
- IN_W, 12, DUT input width (e.g. Op[1:0], Funct[5:0], Rd[3:0]).
- OUT_W, 15, DUT output width.
- DEPTH, 256, vector RAM entries (power of two).
- AW, log2(DEPTH), vector address width.
- SETTLE, 1, cycles between driving dut_in and sampling dut_out (>=1).
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a run from address 0.
- vec_we  in  1  vector RAM write enable.
- vec_waddr  in  AW  write address.
- vec_wdata  in  VW=1+IN_W+2*OUT_W  vector word {valid, stim, exp, mask}, valid = MSB.
- dut_in  out  IN_W  stimulus to DUT.
- dut_out  in  OUT_W  DUT response.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start or reset.
- pass  out  1  done and errors==0.
- vec_count  out  AW+1  vectors checked in current/last run.
- errors  out  ERR_W  mismatch count, saturating.
- first_err_idx  out  AW  index of first failing vector.
- first_err_got  out  OUT_W  dut_out captured at first failure.

Behaviour:
- Reset values:
  - Outputs: dut_in=0, busy=0, done=0, pass=0, vec_count=0, errors=0, first_err_idx=0, first_err_got=0.
  - Internal: FSM=IDLE, idx=0.
  - RAM contents are not reset.
- Vector RAM:
  - Synchronous write on vec_we, accepted only when busy=0; ignored while busy.
  - Synchronous read, 1-cycle latency.
- FSM states: IDLE, FETCH, APPLY, WAIT, CHECK, DONE.
  - IDLE: start -> FETCH; clear idx, vec_count, errors, first_err_*, done. busy=1 from the next cycle.
  - FETCH: present idx to RAM -> APPLY.
  - APPLY: latch RAM word into the vector register. valid=0 -> DONE (terminator, not counted). Otherwise dut_in<=stim, wait counter<=SETTLE-1 -> WAIT.
  - WAIT: decrement; at 0 -> CHECK. dut_in held stable.
  - CHECK:
    - mism = |((dut_out ^ exp) & mask).
    - On mism: errors increments, saturating at 2^ERR_W-1. If errors was 0, capture first_err_idx=idx and first_err_got=dut_out.
    - vec_count++. If idx==DEPTH-1 -> DONE (wrap-around prohibited); else idx++ -> FETCH.
  - DONE: busy=0, done=1, pass=(errors==0). start -> restart exactly as from IDLE.
- Timing: each vector takes SETTLE+3 cycles. dut_in changes only on entry to WAIT; dut_out is sampled in the last cycle of CHECK.
- Edge cases:
  - start while busy: ignored.
  - start coincident with reset: reset wins.
  - Reset mid-run: immediate return to IDLE with reset values; dut_in=0.
  - Empty RAM (word 0 valid=0): DONE after 2 cycles, vec_count=0, pass=1.
  - mask=0: vector always passes but is counted.
- The DUT sees dut_in as registered; the checker adds no combinational path from dut_out to dut_in.

Test Plan:
- Load 3 vectors plus a terminator into the decoder DUT, all matching expected outputs, with SETTLE=1, then pulse start -> done after 2+3*4=14 cycles from FETCH, vec_count=3, errors=0, pass=1.
- Vector 1 exp differs in bit 0 with mask all-ones -> errors=1, first_err_idx=1, first_err_got=actual DUT value, pass=0.
- Same mismatch with that mask bit cleared -> errors=0, pass=1.
- DEPTH=4 with all 4 valid, no terminator -> DONE after idx 3, vec_count=4, no wrap.
- Assert reset in WAIT of vector 2 -> next cycle busy=0, dut_in=0, errors=0. Second start: run completes normally. vec_we during a run: RAM unchanged (verify by readback run).
- ERR_W=2 with 5 failing vectors -> errors saturates at 3, first_err_idx=0. Empty RAM -> done with vec_count=0, pass=1.
